mine_placer: RTL and testbench
==============================

// Module: mine_placer
// PURPOSE
// - Upstream stage of the Board cell memory: clears the board, then seeds NUM_MINES
//   distinct pseudo-random mines and fires one incAdjacent per mine so every cell
//   ends holding its neighbour-mine count.
// - Drives Board's read/write ports directly. Game control owns `start`, `done` and
//   the safe cell (the first-click cell, which is never mined).
// PARAMETERS
// - WIDTH      8        board columns (matches Board width)
// - HEIGHT     8        board rows (matches Board height)
// - BUS_WIDTH  8        cell word width (matches Board busWidth); must be >= 5
// - NUM_MINES  10       mines per game; 1..WIDTH*HEIGHT-1
// - SEED       16'hACE1 LFSR reset value; nonzero
// PORTS
// - clk         in   1         rising-edge clock
// - reset       in   1         asynchronous, active-low reset
// - start       in   1         1-cycle request to build a new board; ignored while busy
// - safeX       in   XW        safe-cell column, sampled on the accepted start (XW=$clog2(WIDTH))
// - safeY       in   YW        safe-cell row, sampled on the accepted start (YW=$clog2(HEIGHT))
// - readValue   in   BUS_WIDTH Board cell at (readX,readY); combinational
// - readX       out  XW        Board read column
// - readY       out  YW        Board read row
// - writeEn     out  1         Board write strobe
// - incAdjacent out  1         Board neighbour-increment strobe; centre = (writeX,writeY)
// - writeX      out  XW        Board write/centre column
// - writeY      out  YW        Board write/centre row
// - writeValue  out  BUS_WIDTH Board write data
// - busy        out  1         high from the cycle after an accepted start until done
// - done        out  1         1-cycle pulse when the board is complete
// BEHAVIOUR
// - Reset (reset=0): state IDLE, LFSR=SEED, mineCnt=0, cellIdx=0, all outputs 0.
// - LFSR: 16-bit Fibonacci with taps 16,14,13,11. Steps every clock in every state.
//   If it is ever 0, it reloads SEED.
// - Cell encoding: bit BUS_WIDTH-1 = MINE flag; bits [3:0] = neighbour count (0..8).
//   Incrementing a mine cell leaves the flag intact.
// - FSM:
//   - IDLE: on start, latch safeX/safeY, set cellIdx=0 -> CLEAR.
//   - CLEAR: writeEn=1, writeValue=0, (writeX,writeY)=cellIdx; cellIdx++.
//     After the WIDTH*HEIGHT-th write (cellIdx=WIDTH*HEIGHT-1) -> PICK.
//   - PICK: register candidate candX=lfsr[XW-1:0], candY=lfsr[XW+YW-1:XW] -> CHECK.
//   - CHECK: readX/readY=cand. Reject (-> PICK) if candX>=WIDTH, candY>=HEIGHT,
//     cand==safe cell, or readValue[MINE]=1. Otherwise -> WRITE.
//   - WRITE: writeEn=1, writeX/Y=cand, writeValue=readValue|MINE (keeps the count
//     already accumulated in the cell) -> INC.
//   - INC: incAdjacent=1, writeEn=0, writeX/Y=cand; mineCnt++.
//     If mineCnt==NUM_MINES-1 -> DONE, else -> PICK.
//   - DONE: done=1 for one cycle, mineCnt=0 -> IDLE.
// - Output timing: writeEn and incAdjacent are never high in the same cycle. All
//   strobes are registered-state decodes, and Board samples them on the next clk edge.
// - busy = (state != IDLE) && (state != DONE).
// - Latency: CLEAR takes WIDTH*HEIGHT cycles. Each mine takes >= 4 cycles (PICK,
//   CHECK, WRITE, INC) plus 2 cycles per rejected candidate.
// - start while busy or in DONE: ignored, with no change to the latched safe cell.
// - Reset mid-operation: immediate return to IDLE, strobes drop asynchronously, and
//   board contents are undefined until the next start.
// - Board widths are exact powers of two here, so out-of-range rejection is a no-op
//   at the defaults but stays in the RTL for other sizes.
// STRUCTURE
// - board_defs.vh: MINE_BIT index, COUNT_MSB, state encodings (IDLE, CLEAR, PICK,
//   CHECK, WRITE, INC, DONE, 3 bits), XW/YW width macros. Shared with Board and the
//   reveal logic.
// - Sub-module lfsr16 (clk, reset, seed, q): free-running generator with zero-lockup
//   reload. The FSM, counters and port muxing live in mine_placer.
// TESTING
// - Clear: preload a Board model with 8'h55 everywhere, pulse start -> exactly 64
//   writeEn cycles of value 0, covering (0,0)..(7,7) in row-major order.
// - Count: defaults, start with safe cell (3,3) -> done after mineCnt=10.
//   - Board holds exactly 10 cells with bit7 set.
//   - Cell (3,3) has bit7=0.
//   - Every non-mine cell's [3:0] equals the number of mined neighbours.
// - Duplicates: force the LFSR so the same (5,2) comes up twice -> the second CHECK
//   rejects it, with no second WRITE or INC at (5,2).
// - Safe cell: force the candidate = (safeX,safeY)=(0,7) -> rejected, cell stays 0.
// - Busy: start pulses during CLEAR and during INC -> ignored.
//   - Exactly one done pulse.
//   - safe cell unchanged from the first start.
// - Reset: drop reset during the 4th mine's WRITE -> next cycle all outputs 0,
//   state IDLE. A new start then completes a full 64-cell clear and 10 mines.

Source files
------------

// File: rtl/mine_placer_pkg.sv
// Shared definitions for the mine placer: FSM state encoding and the LFSR step.
package mine_placer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    PICK  = 3'd2,
    CHECK = 3'd3,
    WRITE = 3'd4,
    INC   = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

endpackage

// File: rtl/mine_placer_lfsr16.sv
// Free-running 16-bit LFSR; an all-zero state (which would lock up) reloads the seed.
module lfsr16
  import mine_placer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= seed;
    end else if (q == 16'd0) begin
      q <= seed;
    end else begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/mine_placer.sv
// Clears the board, then places NUM_MINES distinct random mines (never on the safe cell)
// and strobes incAdjacent once per mine so Board accumulates neighbour counts.
module mine_placer
  import mine_placer_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          HEIGHT    = 8,
  parameter int          BUS_WIDTH = 8,
  parameter int          NUM_MINES = 10,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(WIDTH)-1:0]   safeX,
  input  logic [$clog2(HEIGHT)-1:0]  safeY,
  input  logic [BUS_WIDTH-1:0]       readValue,
  output logic [$clog2(WIDTH)-1:0]   readX,
  output logic [$clog2(HEIGHT)-1:0]  readY,
  output logic                       writeEn,
  output logic                       incAdjacent,
  output logic [$clog2(WIDTH)-1:0]   writeX,
  output logic [$clog2(HEIGHT)-1:0]  writeY,
  output logic [BUS_WIDTH-1:0]       writeValue,
  output logic                       busy,
  output logic                       done
);

  localparam int XW       = $clog2(WIDTH);
  localparam int YW       = $clog2(HEIGHT);
  localparam int MINE_BIT = BUS_WIDTH - 1;
  localparam int CW       = $clog2(NUM_MINES + 1);

  localparam logic [XW-1:0]        X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0]        Y_LAST    = YW'(HEIGHT - 1);
  localparam logic [CW-1:0]        CNT_LAST  = CW'(NUM_MINES - 1);
  localparam logic [BUS_WIDTH-1:0] MINE_MASK = {1'b1, {(BUS_WIDTH-1){1'b0}}};

  state_t        state, state_next;
  logic [XW-1:0] safe_x, cell_x, cand_x;
  logic [YW-1:0] safe_y, cell_y, cand_y;
  logic [CW-1:0] mine_cnt;
  logic [15:0]   lfsr_q;
  logic          clear_last;
  logic          cand_reject;
  logic          unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:XW+YW];
  assign clear_last  = (cell_x == X_LAST) && (cell_y == Y_LAST);

  // Out-of-range tests only matter when the board is not a power of two wide/high.
  assign cand_reject = (int'(cand_x) >= WIDTH) || (int'(cand_y) >= HEIGHT) ||
                       ((cand_x == safe_x) && (cand_y == safe_y)) ||
                       readValue[MINE_BIT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    readX       = '0;
    readY       = '0;
    writeEn     = 1'b0;
    incAdjacent = 1'b0;
    writeX      = '0;
    writeY      = '0;
    writeValue  = '0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        writeEn = 1'b1;
        writeX  = cell_x;
        writeY  = cell_y;
        if (clear_last) state_next = PICK;
      end
      PICK: state_next = CHECK;
      CHECK: begin
        readX      = cand_x;
        readY      = cand_y;
        state_next = cand_reject ? PICK : WRITE;
      end
      WRITE: begin
        // Keep the read address on the candidate so its accumulated count survives.
        readX      = cand_x;
        readY      = cand_y;
        writeEn    = 1'b1;
        writeX     = cand_x;
        writeY     = cand_y;
        writeValue = readValue | MINE_MASK;
        state_next = INC;
      end
      INC: begin
        incAdjacent = 1'b1;
        writeX      = cand_x;
        writeY      = cand_y;
        state_next  = (mine_cnt == CNT_LAST) ? DONE : PICK;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      safe_x   <= '0;
      safe_y   <= '0;
      cell_x   <= '0;
      cell_y   <= '0;
      cand_x   <= '0;
      cand_y   <= '0;
      mine_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            safe_x <= safeX;
            safe_y <= safeY;
            cell_x <= '0;
            cell_y <= '0;
          end
        end
        CLEAR: begin
          if (cell_x == X_LAST) begin
            cell_x <= '0;
            cell_y <= (cell_y == Y_LAST) ? '0 : cell_y + YW'(1);
          end else begin
            cell_x <= cell_x + XW'(1);
          end
        end
        PICK: begin
          cand_x <= lfsr_q[XW-1:0];
          cand_y <= lfsr_q[XW+YW-1:XW];
        end
        INC:     mine_cnt <= mine_cnt + CW'(1);
        DONE:    mine_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer with a Board model and a placement-order predictor.
module tb_mine_placer;

  localparam int          NM   = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] safeX = '0, safeY = '0;
  logic [7:0] readValue;
  logic [2:0] readX, readY, writeX, writeY;
  logic       writeEn, incAdjacent, busy, done;
  logic [7:0] writeValue;

  mine_placer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .safeX       (safeX),
    .safeY       (safeY),
    .readValue   (readValue),
    .readX       (readX),
    .readY       (readY),
    .writeEn     (writeEn),
    .incAdjacent (incAdjacent),
    .writeX      (writeX),
    .writeY      (writeY),
    .writeValue  (writeValue),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Board model: registered write / neighbour increment, combinational read.
  logic [7:0] board [64];
  logic       fill55 = 1'b0;
  int         bnx, bny;
  assign readValue = board[{readY, readX}];

  always @(posedge clk) begin
    if (fill55) begin
      for (int i = 0; i < 64; i++) board[i] <= 8'h55;
    end else begin
      if (writeEn) board[{writeY, writeX}] <= writeValue;
      if (incAdjacent) begin
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            bnx = int'(writeX) + dx;
            bny = int'(writeY) + dy;
            if ((dx != 0 || dy != 0) && bnx >= 0 && bnx < 8 && bny >= 0 && bny < 8)
              board[bny*8 + bnx] <= board[bny*8 + bnx] + 8'd1;
          end
        end
      end
    end
  end

  function automatic logic [15:0] step(input logic [15:0] l);
    if (l == 16'd0) return SEED;
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  logic [15:0] lfsr_m;
  always @(posedge clk or negedge reset) begin
    if (!reset) lfsr_m <= SEED;
    else        lfsr_m <= step(lfsr_m);
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected mine order, given the LFSR value in the cycle start is accepted.
  int exp_pos [NM];
  int pred_dups, pred_safe_hits;

  task automatic predict(input logic [15:0] l0, input int sx, input int sy);
    logic [15:0] l;
    bit          mined [64];
    int          n, cx, cy;
    l = l0;
    for (int i = 0; i < 65; i++) l = step(l);
    for (int i = 0; i < 64; i++) mined[i] = 1'b0;
    n = 0; pred_dups = 0; pred_safe_hits = 0;
    while (n < NM) begin
      cx = int'(l[2:0]);
      cy = int'(l[5:3]);
      if (cx == sx && cy == sy) begin
        pred_safe_hits++;
        l = step(step(l));
      end else if (mined[cy*8 + cx]) begin
        pred_dups++;
        l = step(step(l));
      end else begin
        mined[cy*8 + cx] = 1'b1;
        exp_pos[n] = cy*8 + cx;
        n++;
        for (int i = 0; i < 4; i++) l = step(l);
      end
    end
  endtask

  int clear_cnt, mine_wr, inc_cnt, done_cnt;

  task automatic reset_counters();
    clear_cnt = 0; mine_wr = 0; inc_cnt = 0; done_cnt = 0;
  endtask

  // Called once per negedge by the driving process.
  task automatic sample();
    if (writeEn && incAdjacent) check("strobe_overlap", 1, 0);
    if (writeEn && !writeValue[7]) begin
      check("clear_value", int'(writeValue), 0);
      check("clear_order", int'(writeY)*8 + int'(writeX), clear_cnt);
      clear_cnt++;
    end
    if (writeEn && writeValue[7]) begin
      if (mine_wr < NM) check("mine_write_pos", int'(writeY)*8 + int'(writeX), exp_pos[mine_wr]);
      else              check("mine_write_extra", mine_wr + 1, NM);
      mine_wr++;
    end
    if (incAdjacent) begin
      if (inc_cnt < NM) check("inc_pos", int'(writeY)*8 + int'(writeX), exp_pos[inc_cnt]);
      else              check("inc_extra", inc_cnt + 1, NM);
      inc_cnt++;
    end
    if (done) done_cnt++;
  endtask

  task automatic board_scan(input int sx, input int sy);
    int mines, bad, nbr, nx, ny;
    mines = 0; bad = 0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        nbr = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            nx = x + dx; ny = y + dy;
            if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8)
              if (board[ny*8 + nx][7]) nbr++;
          end
        end
        if (board[y*8 + x][7]) mines++;
        if (int'(board[y*8 + x][6:0]) != nbr) bad++;
      end
    end
    check("mine_total", mines, NM);
    check("safe_unmined", int'(board[sy*8 + sx][7]), 0);
    check("adjacent_bad_cells", bad, 0);
  endtask

  task automatic run_game(input int sx0, input int sy0, input bit safe_first, input bit poke);
    int          sx, sy, cyc;
    bit          poked_clear, poked_inc;
    logic [15:0] l;
    sx = sx0; sy = sy0;
    if (safe_first) begin
      l = lfsr_m;
      for (int i = 0; i < 65; i++) l = step(l);
      sx = int'(l[2:0]);
      sy = int'(l[5:3]);
    end
    reset_counters();
    poked_clear = 1'b0; poked_inc = 1'b0;
    safeX = 3'(sx); safeY = 3'(sy);
    start = 1'b1;
    predict(lfsr_m, sx, sy);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      sample();
      if (poke && !poked_clear && clear_cnt == 10) begin
        poked_clear = 1'b1; start = 1'b1; safeX = 3'(sx + 1); safeY = 3'(sy + 2);
      end else if (poke && !poked_inc && inc_cnt == 2) begin
        poked_inc = 1'b1; start = 1'b1; safeX = 3'(sx + 3); safeY = 3'(sy + 1);
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (done_cnt == 0) check("done_within_bound", 0, 1);
    for (int i = 0; i < 20; i++) begin
      sample();
      @(negedge clk);
    end
    check("clear_writes", clear_cnt, 64);
    check("mine_writes", mine_wr, NM);
    check("inc_pulses", inc_cnt, NM);
    check("done_pulses", done_cnt, 1);
    check("busy_idle", int'(busy), 0);
    board_scan(sx, sy);
    $display("game safe=(%0d,%0d) dups=%0d safe_hits=%0d cycles=%0d", sx, sy, pred_dups, pred_safe_hits, cyc);
  endtask

  initial begin
    logic [15:0] l;
    int          d, cyc;
    bit          found;

    fill55 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_strobes", int'({writeEn, incAdjacent, busy, done}), 0);
    check("rst_addr", int'({readX, readY, writeX, writeY}), 0);
    check("rst_wvalue", int'(writeValue), 0);
    fill55 = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("board_preloaded", int'(board[27]), 8'h55);

    // Safe cell chosen as the first candidate, with start pokes during CLEAR and INC.
    run_game(0, 0, 1'b1, 1'b1);

    // Delay the start until the predicted sequence contains a duplicate candidate.
    found = 1'b0;
    l = lfsr_m;
    for (d = 0; d < 400; d++) begin
      predict(l, 0, 7);
      if (pred_dups > 0) begin
        found = 1'b1;
        break;
      end
      l = step(l);
    end
    if (!found) check("dup_search", d, -1);
    repeat (d) @(negedge clk);
    run_game(0, 7, 1'b0, 1'b0);

    // Reset during the 4th mine's WRITE.
    reset_counters();
    safeX = 3'd3; safeY = 3'd3;
    start = 1'b1;
    predict(lfsr_m, 3, 3);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (1) begin
      sample();
      if (mine_wr == 4) break;
      if (cyc > 3000) begin
        check("fourth_write_within_bound", 0, 1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("wr4_strobe", int'(writeEn), 1);
    reset = 1'b0;
    #1;
    check("midrst_strobes", int'({writeEn, incAdjacent, busy, done}), 0);
    check("midrst_addr", int'({readX, readY, writeX, writeY}), 0);
    check("midrst_wvalue", int'(writeValue), 0);
    @(negedge clk);
    check("midrst_busy_held", int'(busy), 0);
    reset = 1'b1;
    run_game(3, 3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
